// File: rtl/wptr_full_gen_pkg.sv
// Shared FIFO defaults: pointer geometry, almost-full level and synchronizer depth.
package wptr_full_gen_pkg;

    localparam int unsigned AddrSizeDefault    = 7;
    localparam int unsigned AfullThreshDefault = 120;
    localparam int unsigned SyncStagesDefault  = 2;

    localparam int unsigned DepthDefault = 1 << AddrSizeDefault;

    typedef logic [AddrSizeDefault:0] ptr_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; bit i is the XOR of gray bits WIDTH-1 down to i.
module gray2bin #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_full_gen.sv
// Write-side pointer, full/almost-full flags, occupancy and sticky overflow of an async FIFO.
module wptr_full_gen
    import wptr_full_gen_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = AddrSizeDefault,
    parameter int unsigned AFULL_THRESH = AfullThreshDefault
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf
);

    localparam int unsigned PtrW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AfullThr = PtrW'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wcount_q, wcount_d;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] full_cmp;
    logic              wfull_q, wfull_d;
    logic              wafull_q, wafull_d;
    logic              wovf_q, wovf_d;
    logic              winc_ok;

    gray2bin #(
        .WIDTH(PtrW)
    ) u_rptr_g2b (
        .gray(wq2_rptr),
        .bin (rbin_s)
    );

    // Full when the next write pointer equals the read pointer with the top two Gray bits flipped.
    assign full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_comb begin
        winc_ok  = winc & ~wfull_q;
        wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, winc_ok};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wcount_d = wbin_d - rbin_s;
        wfull_d  = (wptr_d == full_cmp);
        wafull_d = (wcount_d >= AfullThr);
        wovf_d   = wovf_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    // Reset gates the RAM strobe so nothing is written in a reset cycle.
    assign wen    = winc_ok & ~wrst;
    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wptr   = wptr_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wcount = wcount_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed bench for wptr_full_gen: vector tables plus fill, wrap and mid-fill reset sequences.
module tb_wptr_full_gen;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic [7:0] wq2_rptr = '0;
    logic       wen;
    logic [6:0] waddr;
    logic [7:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [7:0] wcount;
    logic       wovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wclk = ~wclk;

    wptr_full_gen #(
        .ADDRSIZE    (7),
        .AFULL_THRESH(120)
    ) dut (
        .wclk    (wclk),
        .wrst    (wrst),
        .winc    (winc),
        .wq2_rptr(wq2_rptr),
        .wen     (wen),
        .waddr   (waddr),
        .wptr    (wptr),
        .wfull   (wfull),
        .wafull  (wafull),
        .wcount  (wcount),
        .wovf    (wovf)
    );

    typedef struct {
        logic       rst;
        logic       inc;
        logic [7:0] rptr;
        logic       e_wen;
        logic       e_full;
        logic       e_afull;
        logic [7:0] e_count;
        logic [6:0] e_addr;
        logic [7:0] e_ptr;
        logic       e_ovf;
    } vec_t;

    vec_t reset_tbl[3];
    vec_t post_tbl[5];

    function automatic logic [7:0] gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, check the combinational strobe, then clock and check state.
    task automatic apply(input vec_t v, input string name);
        wrst     = v.rst;
        winc     = v.inc;
        wq2_rptr = v.rptr;
        #1;
        chk({name, ".wen"}, 32'(wen), 32'(v.e_wen));
        @(posedge wclk);
        #1;
        chk({name, ".wfull"},  32'(wfull),  32'(v.e_full));
        chk({name, ".wafull"}, 32'(wafull), 32'(v.e_afull));
        chk({name, ".wcount"}, 32'(wcount), 32'(v.e_count));
        chk({name, ".waddr"},  32'(waddr),  32'(v.e_addr));
        chk({name, ".wptr"},   32'(wptr),   32'(v.e_ptr));
        chk({name, ".wovf"},   32'(wovf),   32'(v.e_ovf));
    endtask

    task automatic write_step(input logic [7:0] rptr, input logic [7:0] exp_bin,
                              input logic [7:0] exp_cnt, input string name);
        wrst     = 1'b0;
        winc     = 1'b1;
        wq2_rptr = rptr;
        #1;
        chk({name, ".wen"}, 32'(wen), 32'd1);
        @(posedge wclk);
        #1;
        chk({name, ".wcount"}, 32'(wcount), 32'(exp_cnt));
        chk({name, ".wptr"},   32'(wptr),   32'(gray(exp_bin)));
        chk({name, ".waddr"},  32'(waddr),  32'(exp_bin[6:0]));
    endtask

    initial begin
        logic [7:0] bin;
        logic [7:0] prev_ptr;
        bit         seen_wrap;

        //            rst  inc  rptr   wen  full afl  cnt    addr   ptr    ovf
        reset_tbl[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h00, 1'b0};
        reset_tbl[1] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h00, 1'b0};
        reset_tbl[2] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 8'h00, 1'b0};

        // After the fill: wbin = 128, wptr = 0xC0, full.
        post_tbl[0] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h80, 7'h00, 8'hC0, 1'b1};
        post_tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h80, 7'h00, 8'hC0, 1'b1};
        post_tbl[2] = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 7'h00, 8'hC0, 1'b1};
        post_tbl[3] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h80, 7'h01, 8'hC1, 1'b1};
        post_tbl[4] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 7'h01, 8'hC1, 1'b1};

        #2;
        for (int i = 0; i < 3; i++) apply(reset_tbl[i], $sformatf("reset%0d", i));

        // Fill 128 words with the reader parked at 0.
        for (int i = 1; i <= 128; i++) begin
            write_step(8'h00, 8'(i), 8'(i), $sformatf("fill%0d", i));
            chk($sformatf("fill%0d.wafull", i), 32'(wafull), 32'(i >= 120));
            chk($sformatf("fill%0d.wfull", i),  32'(wfull),  32'(i == 128));
        end

        for (int i = 0; i < 5; i++) apply(post_tbl[i], $sformatf("post%0d", i));

        // Wrap-around with the reader trailing by four words.
        wrst = 1'b1; winc = 1'b0; wq2_rptr = '0;
        @(posedge wclk); #1;
        chk("wrap.ovf_cleared", 32'(wovf), 32'd0);
        for (int i = 1; i <= 4; i++) write_step(8'h00, 8'(i), 8'(i), $sformatf("prime%0d", i));
        bin       = 8'd4;
        prev_ptr  = wptr;
        seen_wrap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            write_step(gray(bin - 8'd3), bin + 8'd1, 8'd4, $sformatf("wrap%0d", i));
            bin = bin + 8'd1;
            chk($sformatf("wrap%0d.wfull", i), 32'(wfull), 32'd0);
            chk($sformatf("wrap%0d.onebit", i), 32'($countones(prev_ptr ^ wptr)), 32'd1);
            if (wptr == 8'h00) seen_wrap = 1'b1;
            prev_ptr = wptr;
        end
        chk("wrap.seen_zero", 32'(seen_wrap), 32'd1);
        chk("wrap.final_addr", 32'(waddr), 32'd48);

        // Reset in the middle of a fill.
        wrst = 1'b1; winc = 1'b0; wq2_rptr = '0;
        @(posedge wclk); #1;
        for (int i = 1; i <= 50; i++) write_step(8'h00, 8'(i), 8'(i), $sformatf("mid%0d", i));
        wrst = 1'b1; winc = 1'b1;
        #1;
        chk("midrst.wen", 32'(wen), 32'd0);
        @(posedge wclk); #1;
        chk("midrst.wcount", 32'(wcount), 32'd0);
        chk("midrst.waddr",  32'(waddr),  32'd0);
        chk("midrst.wptr",   32'(wptr),   32'd0);
        write_step(8'h00, 8'd1, 8'd1, "resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
